// File: rtl/midi_rx.sv
// MIDI receiver front end: UART 8N1 byte recovery plus a running-status parser
// that turns note-on/note-off channel messages into single-cycle event strobes.
module midi_rx #(
    parameter int CLKS_PER_BIT = 320
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       rxData_i,
    output logic       noteValid_o,
    output logic       noteOn_o,
    output logic [6:0] note_o,
    output logic [6:0] velocity_o,
    output logic [3:0] channel_o,
    output logic       frameErr_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic             sync1_q, rx_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_stb;
    logic             frame_err_d, frame_err_q;

    // Running status keeps bit 7 set while valid, so zero means "none".
    logic [7:0]       rs_q, rs_d;
    logic             idx_q, idx_d;
    logic [6:0]       note_byte_q, note_byte_d;

    logic             note_valid_q, note_valid_d;
    logic             note_on_q, note_on_d;
    logic [6:0]       note_q, note_d;
    logic [6:0]       vel_q, vel_d;
    logic [3:0]       chan_q, chan_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_stb    = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        bit_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        byte_stb = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rs_d         = rs_q;
        idx_d        = idx_q;
        note_byte_d  = note_byte_q;
        note_valid_d = 1'b0;
        note_on_d    = note_on_q;
        note_d       = note_q;
        vel_d        = vel_q;
        chan_d       = chan_q;
        if (byte_stb) begin
            if (shift_q[7]) begin
                if (shift_q[7:3] == 5'b11111) begin
                    // Realtime bytes may sit between data bytes; leave parser untouched.
                    rs_d = rs_q;
                end else if (shift_q[7:4] == 4'hF) begin
                    rs_d  = 8'h00;
                    idx_d = 1'b0;
                end else begin
                    rs_d  = shift_q;
                    idx_d = 1'b0;
                end
            end else if (rs_q[7]) begin
                unique case (rs_q[6:4])
                    3'b000, 3'b001: begin
                        if (!idx_q) begin
                            note_byte_d = shift_q[6:0];
                            idx_d       = 1'b1;
                        end else begin
                            note_valid_d = 1'b1;
                            note_d       = note_byte_q;
                            vel_d        = shift_q[6:0];
                            chan_d       = rs_q[3:0];
                            note_on_d    = rs_q[4] && (shift_q[6:0] != 7'd0);
                            idx_d        = 1'b0;
                        end
                    end
                    3'b100, 3'b101: begin
                        idx_d = 1'b0;
                    end
                    default: begin
                        idx_d = ~idx_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            frame_err_q  <= 1'b0;
            rs_q         <= 8'h00;
            idx_q        <= 1'b0;
            note_valid_q <= 1'b0;
            note_on_q    <= 1'b0;
            note_q       <= 7'd0;
            vel_q        <= 7'd0;
            chan_q       <= 4'd0;
        end else begin
            sync1_q      <= rxData_i;
            rx_s_q       <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            frame_err_q  <= frame_err_d;
            rs_q         <= rs_d;
            idx_q        <= idx_d;
            note_valid_q <= note_valid_d;
            note_on_q    <= note_on_d;
            note_q       <= note_d;
            vel_q        <= vel_d;
            chan_q       <= chan_d;
        end
    end

    // Pure datapath holding registers; their contents only matter once qualified.
    always_ff @(posedge clk_i) begin
        shift_q     <= shift_d;
        note_byte_q <= note_byte_d;
    end

    assign noteValid_o = note_valid_q;
    assign noteOn_o    = note_on_q;
    assign note_o      = note_q;
    assign velocity_o  = vel_q;
    assign channel_o   = chan_q;
    assign frameErr_o  = frame_err_q;

endmodule

// File: doc/midi_rx.md
Name: midi_rx

Overview:
- Front-end stage of the synth datapath.
- Receives a serial MIDI stream (UART, 8N1, idle high) on one pin, recovers bytes, and parses running-status channel voice messages.
- Presents decoded note-on/note-off events as single-cycle strobes to the voice/oscillator allocation logic downstream.

Parameters:
- CLKS_PER_BIT, 320, system clocks per UART bit (10 MHz / 31250 baud); must be even and >= 8.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter (derived, not overridden).

Ports:
- clk_i  input  1  system clock, all logic on rising edge
- nrst_i  input  1  reset, asynchronous assert, active-low
- rxData_i  input  1  raw asynchronous MIDI serial line, idle high
- noteValid_o  output  1  one-cycle strobe: a complete note message was decoded
- noteOn_o  output  1  1 = note-on with velocity > 0; 0 = note-off or note-on with velocity 0
- note_o  output  7  MIDI note number
- velocity_o  output  7  MIDI velocity as received
- channel_o  output  4  MIDI channel (status low nibble)
- frameErr_o  output  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Reset (nrst_i low, asynchronous):
  - All outputs 0.
  - Synchronizer flops 1.
  - UART FSM in IDLE.
  - Running status cleared; data-byte index 0.
- Input path: rxData_i passes through a 2-flop synchronizer; all decisions use the second-flop output (rx_s).
- UART FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s == 0 -> START, counter cleared.
  - START: after CLKS_PER_BIT/2 clocks, sample rx_s.
    - 1 -> IDLE (glitch rejected, no strobe).
    - 0 -> DATA, bit index 0.
  - DATA: sample every CLKS_PER_BIT clocks. LSB first, shifted into the byte register. After bit 7 -> STOP.
  - STOP: sample CLKS_PER_BIT clocks after bit 7.
    - rx_s == 1: byte is valid; raise the internal byte strobe for that cycle; -> IDLE.
    - rx_s == 0: frameErr_o = 1 for one cycle; byte discarded; -> WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s == 1 (break tolerance), then -> IDLE.
- Parser: acts only on the internal byte strobe.
  - 0xF8-0xFF (realtime): ignored completely. No change to running status or data index. Legal between the data bytes of a message.
  - 0xF0-0xF7 (system common/SysEx): running status cleared; data index 0; following data bytes ignored.
  - 0x80-0xEF (channel status): stored as running status; data index 0.
  - Data byte (bit7 = 0) with no running status: ignored.
  - Data bytes for 0xC0/0xD0 running status: one-byte messages; consumed, no output.
  - Data bytes for 0xA0/0xB0/0xE0 running status: two-byte messages; consumed, no output.
  - Data bytes for 0x80/0x90 running status:
    - Index 0: store as note; index -> 1.
    - Index 1: emit event; index -> 0; running status kept (running-status reuse).
- Event output:
  - Registered, one cycle after the strobe of the second data byte.
  - noteValid_o high exactly one cycle.
  - note_o, velocity_o, channel_o, noteOn_o update in the same cycle and hold until the next event.
  - noteOn_o = (status 0x9n) AND (velocity != 0).
- Latency: noteValid_o rises 1 clock after the stop-bit sample of the final data byte.
- frameErr_o and noteValid_o never assert in the same cycle.
- A framing error does not reset the parser; the next valid byte continues the message.
- Reset mid-frame or mid-message: the partial byte and partial message are lost; no strobe is produced.

Test Plan (bench sets CLKS_PER_BIT = 16):
- Send 0x93, 0x3C, 0x64 -> one noteValid_o pulse with channel_o = 3, note_o = 0x3C, velocity_o = 0x64, noteOn_o = 1; pulse 1 clk after the third stop sample.
- Running status: 0x90, 0x40, 0x7F, 0x40, 0x00 -> two pulses. First noteOn_o = 1, velocity 0x7F. Second noteOn_o = 0, velocity 0x00, note 0x40.
- Interleaving: 0x85, 0x30, 0xF8, 0x10 -> one pulse with noteOn_o = 0, channel 5, note 0x30, velocity 0x10. Realtime byte has no effect.
- Filtering: 0xC2, 0x05, then 0xF0, 0x11, 0x22, 0xF7, then 0x22, 0x33 -> no noteValid_o pulses.
- Framing: 0x90 sent with the stop bit low, line held low 40 clks, then 0x91, 0x3C, 0x50 -> frameErr_o pulses once; then one event on channel 1.
- Glitch/reset:
  - 4-clk low pulse on idle line -> no strobes.
  - Assert nrst_i after 0x90, 0x3C -> outputs 0.
  - After release, lone 0x50 -> no pulse.
